// File: rtl/rx_sync_ctrl.sv
// Rx frame sequencer: latches link config, soft-resets the pulse synchronizer, supervises lock,
// then walks preamble and payload bit counting; one rx_done_o pulse with status per frame.
module rx_sync_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_start_i,
  input  logic        rx_abort_i,
  input  logic [8:0]  cfg_rate_i,
  input  logic        cfg_decode_i,
  input  logic [2:0]  cfg_lock_num_i,
  input  logic        cfg_lock_double_i,
  input  logic [5:0]  cfg_boot_bits_i,
  input  logic [11:0] cfg_bit_len_i,
  input  logic [15:0] cfg_lock_timeout_i,
  input  logic        pulse_sync_i,
  input  logic        err_lost_sync_i,
  input  logic        bit_valid_i,
  output logic        dec_rst_n_o,
  output logic [8:0]  set_rate_o,
  output logic        set_decode_o,
  output logic [2:0]  set_lock_num_o,
  output logic        set_lock_double_o,
  output logic        boot_sync_o,
  output logic        form_sync_o,
  output logic        rx_busy_o,
  output logic        rx_done_o,
  output logic [1:0]  rx_status_o,
  output logic [11:0] bit_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRST,
    S_LOCK,
    S_PRE,
    S_DATA,
    S_DONE
  } state_e;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_LOST    = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  state_e      state_q, state_d;
  logic [8:0]  rate_q, rate_d;
  logic        decode_q, decode_d;
  logic [2:0]  lock_num_q, lock_num_d;
  logic        lock_double_q, lock_double_d;
  logic [5:0]  boot_lim_q, boot_lim_d;
  logic [11:0] bit_len_q, bit_len_d;
  logic [15:0] tmo_lim_q, tmo_lim_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [5:0]  boot_cnt_q, boot_cnt_d;
  logic [11:0] bit_cnt_q, bit_cnt_d;
  logic        drst_cnt_q, drst_cnt_d;
  logic [1:0]  status_q, status_d;

  logic        dec_rst_n_q;
  logic        boot_sync_q;
  logic        form_sync_q;
  logic        busy_q;
  logic        done_q;

  logic [5:0]  boot_inc;
  logic [11:0] bit_inc;

  assign boot_inc = boot_cnt_q + 6'd1;
  assign bit_inc  = bit_cnt_q + 12'd1;

  always_comb begin
    state_d       = state_q;
    rate_d        = rate_q;
    decode_d      = decode_q;
    lock_num_d    = lock_num_q;
    lock_double_d = lock_double_q;
    boot_lim_d    = boot_lim_q;
    bit_len_d     = bit_len_q;
    tmo_lim_d     = tmo_lim_q;
    tmo_cnt_d     = tmo_cnt_q;
    boot_cnt_d    = boot_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    drst_cnt_d    = drst_cnt_q;
    status_d      = status_q;

    case (state_q)
      S_IDLE: begin
        if (rx_start_i) begin
          rate_d        = cfg_rate_i;
          decode_d      = cfg_decode_i;
          lock_num_d    = cfg_lock_num_i;
          lock_double_d = cfg_lock_double_i;
          boot_lim_d    = cfg_boot_bits_i;
          bit_len_d     = cfg_bit_len_i;
          tmo_lim_d     = cfg_lock_timeout_i;
          tmo_cnt_d     = '0;
          boot_cnt_d    = '0;
          bit_cnt_d     = '0;
          drst_cnt_d    = 1'b0;
          state_d       = S_DRST;
        end
      end

      S_DRST: begin
        if (rx_abort_i) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if (drst_cnt_q) begin
          state_d = S_LOCK;
        end else begin
          drst_cnt_d = 1'b1;
        end
      end

      S_LOCK: begin
        if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
        // Lost-sync is meaningless before lock, so only abort and timeout can end the frame here.
        if (rx_abort_i) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if ((tmo_lim_q != 16'd0) && (tmo_cnt_q == tmo_lim_q)) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end else if (pulse_sync_i) begin
          state_d = S_PRE;
        end
      end

      S_PRE: begin
        if (bit_valid_i && (boot_cnt_q != boot_lim_q)) boot_cnt_d = boot_inc;
        if (rx_abort_i) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if (err_lost_sync_i) begin
          status_d = ST_LOST;
          state_d  = S_DONE;
        end else if (boot_lim_q == 6'd0) begin
          state_d = S_DATA;
        end else if (bit_valid_i && (boot_inc == boot_lim_q)) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        // A bit arriving with lost-sync is still counted; status reflects the error.
        if (bit_valid_i && (bit_cnt_q != bit_len_q)) bit_cnt_d = bit_inc;
        if (rx_abort_i) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if (err_lost_sync_i) begin
          status_d = ST_LOST;
          state_d  = S_DONE;
        end else if (bit_len_q == 12'd0) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (bit_valid_i && (bit_inc == bit_len_q)) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      rate_q        <= '0;
      decode_q      <= 1'b0;
      lock_num_q    <= '0;
      lock_double_q <= 1'b0;
      boot_lim_q    <= '0;
      bit_len_q     <= '0;
      tmo_lim_q     <= '0;
      tmo_cnt_q     <= '0;
      boot_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      drst_cnt_q    <= 1'b0;
      status_q      <= ST_OK;
      dec_rst_n_q   <= 1'b1;
      boot_sync_q   <= 1'b0;
      form_sync_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rate_q        <= rate_d;
      decode_q      <= decode_d;
      lock_num_q    <= lock_num_d;
      lock_double_q <= lock_double_d;
      boot_lim_q    <= boot_lim_d;
      bit_len_q     <= bit_len_d;
      tmo_lim_q     <= tmo_lim_d;
      tmo_cnt_q     <= tmo_cnt_d;
      boot_cnt_q    <= boot_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      drst_cnt_q    <= drst_cnt_d;
      status_q      <= status_d;
      dec_rst_n_q   <= (state_d != S_DRST);
      boot_sync_q   <= (state_d == S_LOCK) || (state_d == S_PRE);
      form_sync_q   <= (state_d == S_DATA);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
    end
  end

  assign dec_rst_n_o       = dec_rst_n_q;
  assign set_rate_o        = rate_q;
  assign set_decode_o      = decode_q;
  assign set_lock_num_o    = lock_num_q;
  assign set_lock_double_o = lock_double_q;
  assign boot_sync_o       = boot_sync_q;
  assign form_sync_o       = form_sync_q;
  assign rx_busy_o         = busy_q;
  assign rx_done_o         = done_q;
  assign rx_status_o       = status_q;
  assign bit_cnt_o         = bit_cnt_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Directed bench for rx_sync_ctrl; expected completions are queued by the stimulus
// and matched by a monitor on every rx_done_o pulse.
module tb_rx_sync_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        rx_start_i = 1'b0;
  logic        rx_abort_i = 1'b0;
  logic [8:0]  cfg_rate_i = '0;
  logic        cfg_decode_i = 1'b0;
  logic [2:0]  cfg_lock_num_i = 3'd3;
  logic        cfg_lock_double_i = 1'b1;
  logic [5:0]  cfg_boot_bits_i = '0;
  logic [11:0] cfg_bit_len_i = '0;
  logic [15:0] cfg_lock_timeout_i = '0;
  logic        pulse_sync_i = 1'b0;
  logic        err_lost_sync_i = 1'b0;
  logic        bit_valid_i = 1'b0;
  logic        dec_rst_n_o;
  logic [8:0]  set_rate_o;
  logic        set_decode_o;
  logic [2:0]  set_lock_num_o;
  logic        set_lock_double_o;
  logic        boot_sync_o;
  logic        form_sync_o;
  logic        rx_busy_o;
  logic        rx_done_o;
  logic [1:0]  rx_status_o;
  logic [11:0] bit_cnt_o;

  rx_sync_ctrl dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .rx_start_i         (rx_start_i),
    .rx_abort_i         (rx_abort_i),
    .cfg_rate_i         (cfg_rate_i),
    .cfg_decode_i       (cfg_decode_i),
    .cfg_lock_num_i     (cfg_lock_num_i),
    .cfg_lock_double_i  (cfg_lock_double_i),
    .cfg_boot_bits_i    (cfg_boot_bits_i),
    .cfg_bit_len_i      (cfg_bit_len_i),
    .cfg_lock_timeout_i (cfg_lock_timeout_i),
    .pulse_sync_i       (pulse_sync_i),
    .err_lost_sync_i    (err_lost_sync_i),
    .bit_valid_i        (bit_valid_i),
    .dec_rst_n_o        (dec_rst_n_o),
    .set_rate_o         (set_rate_o),
    .set_decode_o       (set_decode_o),
    .set_lock_num_o     (set_lock_num_o),
    .set_lock_double_o  (set_lock_double_o),
    .boot_sync_o        (boot_sync_o),
    .form_sync_o        (form_sync_o),
    .rx_busy_o          (rx_busy_o),
    .rx_done_o          (rx_done_o),
    .rx_status_o        (rx_status_o),
    .bit_cnt_o          (bit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int status;
    int cnt;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_n_i && rx_done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got rx_done_o at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("done_status", int'(rx_status_o), e.status);
        check("done_bit_cnt", int'(bit_cnt_o), e.cnt);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_frame(input int rate, input int boot, input int len, input int tmo,
                             output int n);
    cfg_rate_i         = 9'(rate);
    cfg_boot_bits_i    = 6'(boot);
    cfg_bit_len_i      = 12'(len);
    cfg_lock_timeout_i = 16'(tmo);
    rx_start_i         = 1'b1;
    n                  = cyc;
    tick();
    rx_start_i         = 1'b0;
  endtask

  task automatic send_bits(input int k);
    for (int i = 0; i < k; i++) begin
      bit_valid_i = 1'b1;
      tick();
    end
    bit_valid_i = 1'b0;
  endtask

  // From the cycle after start: two DRST cycles, one-cycle lock, then the preamble bits.
  task automatic reach_data(input int boot);
    tick();
    tick();
    pulse_sync_i = 1'b1;
    tick();
    pulse_sync_i = 1'b0;
    if (boot == 0) tick();
    else send_bits(boot);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int form_seen;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_dec_rst_n", int'(dec_rst_n_o), 1);
    check("rst_busy", int'(rx_busy_o), 0);
    check("rst_boot", int'(boot_sync_o), 0);
    check("rst_done", int'(rx_done_o), 0);
    rst_n_i = 1'b1;
    tick();

    // Nominal FM0 frame
    start_frame(25, 6, 16, 1000, n);
    check("start_busy", int'(rx_busy_o), 1);
    check("start_drst1", int'(dec_rst_n_o), 0);
    check("start_boot_low", int'(boot_sync_o), 0);
    check("latch_rate", int'(set_rate_o), 25);
    check("latch_lock_num", int'(set_lock_num_o), 3);
    check("latch_lock_double", int'(set_lock_double_o), 1);
    cfg_rate_i = 9'd77;
    tick();
    check("start_drst2", int'(dec_rst_n_o), 0);
    tick();
    check("lock_drst_released", int'(dec_rst_n_o), 1);
    check("lock_boot_high", int'(boot_sync_o), 1);
    for (int i = 0; i < 100 && cyc < n + 40; i++) tick();
    pulse_sync_i = 1'b1;
    tick();
    pulse_sync_i = 1'b0;
    check("rate_held", int'(set_rate_o), 25);
    check("pre_boot_high", int'(boot_sync_o), 1);
    for (int i = 1; i <= 22; i++) begin
      if (i == 22) sb.push_back('{0, 16, cyc + 1});
      bit_valid_i = 1'b1;
      tick();
      bit_valid_i = 1'b0;
      check($sformatf("form_after_bit%0d", i), int'(form_sync_o), int'(i >= 6 && i < 22));
    end
    tick();
    check("nominal_busy_low", int'(rx_busy_o), 0);

    // Lock timeout
    start_frame(25, 6, 16, 100, n);
    sb.push_back('{1, 0, n + 104});
    form_seen = 0;
    for (int i = 0; i < 120 && rx_busy_o; i++) begin
      if (form_sync_o) form_seen = 1;
      tick();
    end
    check("tmo_form_never", form_seen, 0);
    check("tmo_idle", int'(rx_busy_o), 0);

    // Lost sync after 5 payload bits; lost sync during LOCK is ignored
    cfg_decode_i = 1'b1;
    start_frame(25, 2, 16, 0, n);
    check("latch_decode", int'(set_decode_o), 1);
    tick();
    tick();
    err_lost_sync_i = 1'b1;
    tick();
    err_lost_sync_i = 1'b0;
    check("lock_ignores_lost", int'(boot_sync_o), 1);
    pulse_sync_i = 1'b1;
    tick();
    pulse_sync_i = 1'b0;
    send_bits(2);
    send_bits(5);
    sb.push_back('{2, 5, cyc + 1});
    err_lost_sync_i = 1'b1;
    tick();
    err_lost_sync_i = 1'b0;
    check("lost_boot_low", int'(boot_sync_o), 0);
    check("lost_form_low", int'(form_sync_o), 0);
    tick();
    cfg_decode_i = 1'b0;

    // Abort beats lost sync; start during DONE is ignored
    start_frame(25, 1, 16, 0, n);
    reach_data(1);
    send_bits(3);
    sb.push_back('{3, 3, cyc + 1});
    rx_abort_i = 1'b1;
    err_lost_sync_i = 1'b1;
    tick();
    rx_abort_i = 1'b0;
    err_lost_sync_i = 1'b0;
    rx_start_i = 1'b1;
    tick();
    rx_start_i = 1'b0;
    check("start_in_done_busy", int'(rx_busy_o), 0);
    tick();
    check("start_in_done_ignored", int'(rx_busy_o), 0);

    // Zero boot and zero length
    start_frame(25, 0, 0, 5, n);
    tick();
    tick();
    pulse_sync_i = 1'b1;
    sb.push_back('{0, 0, n + 6});
    tick();
    pulse_sync_i = 1'b0;
    tick();
    check("zero_data_form", int'(form_sync_o), 1);
    tick();
    check("zero_done_form", int'(form_sync_o), 0);
    tick();

    // Timeout 0 waits in LOCK until abort
    start_frame(25, 0, 0, 0, n);
    repeat (300) tick();
    check("notmo_busy", int'(rx_busy_o), 1);
    check("notmo_boot", int'(boot_sync_o), 1);
    sb.push_back('{3, 0, cyc + 1});
    rx_abort_i = 1'b1;
    tick();
    rx_abort_i = 1'b0;
    tick();

    // Asynchronous reset mid-DATA
    start_frame(40, 1, 16, 0, n);
    reach_data(1);
    send_bits(3);
    check("pre_rst_cnt", int'(bit_cnt_o), 3);
    #2 rst_n_i = 1'b0;
    #1;
    check("arst_busy", int'(rx_busy_o), 0);
    check("arst_form", int'(form_sync_o), 0);
    check("arst_dec_rst_n", int'(dec_rst_n_o), 1);
    check("arst_cnt", int'(bit_cnt_o), 0);
    check("arst_status", int'(rx_status_o), 0);
    check("arst_rate", int'(set_rate_o), 0);
    @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    tick();
    tick();
    check("arst_no_done", int'(rx_done_o), 0);

    start_frame(30, 1, 2, 0, n);
    reach_data(1);
    send_bits(1);
    sb.push_back('{0, 2, cyc + 1});
    send_bits(1);
    tick();
    check("post_rst_rate", int'(set_rate_o), 30);
    repeat (4) tick();

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
